ram_port_arbiter: RTL and testbench

- Shares the single-ported internal RAM between the instruction-fetch port (read-only) and the load/store data port.
- Arbitrates between the two ports, drives the RAM enable/addr/we/oplen/data interface for one transaction at a time, and waits for the RAM valid pulse.
- Returns a registered done/rdata/err pulse to the winning port.
- Sits between the core front-end/LSU and the internal RAM; the GPIO address (0xFFFFFFFF) passes through untouched.

---
 rtl/ram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-ported internal RAM between the fetch port and the load/store port.
// One transaction in flight at a time; the winner gets a registered one-cycle done/rdata/err pulse.
module ram_port_arbiter #(
  parameter bit DATA_PRIO = 1'b0,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_oplen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_enable,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_oplen,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_valid,
  input  logic [31:0] mem_result,
  output logic        busy
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and launch on any request
  // WAIT  | RAM enabled, waiting for mem_valid or timeout
  // RESP  | done/rdata/err presented to the owner for one cycle
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [7:0] TC = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        own_d, own_d_n;
  logic        last_d, last_d_n;
  logic        pick_d;
  logic        mem_enable_n, mem_we_n;
  logic [1:0]  mem_oplen_n;
  logic [31:0] mem_addr_n, mem_wdata_n;
  logic        i_done_n, i_err_n, d_done_n, d_err_n;
  logic [31:0] i_rdata_n, d_rdata_n;
  logic        busy_n;

  // Round-robin hands the conflict to whichever port did not win last time.
  assign pick_d = d_req && (!i_req || DATA_PRIO || !last_d);

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    own_d_n      = own_d;
    last_d_n     = last_d;
    mem_enable_n = 1'b0;
    mem_addr_n   = mem_addr;
    mem_oplen_n  = mem_oplen;
    mem_we_n     = mem_we;
    mem_wdata_n  = mem_wdata;
    i_done_n     = 1'b0;
    i_err_n      = 1'b0;
    i_rdata_n    = 32'h0;
    d_done_n     = 1'b0;
    d_err_n      = 1'b0;
    d_rdata_n    = 32'h0;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          own_d_n      = pick_d;
          last_d_n     = pick_d;
          mem_enable_n = 1'b1;
          cnt_n        = 8'd0;
          state_n      = WAIT;
          if (pick_d) begin
            mem_addr_n  = d_addr;
            mem_oplen_n = d_oplen;
            mem_we_n    = d_we;
            mem_wdata_n = d_wdata;
          end else begin
            mem_addr_n  = i_addr;
            mem_oplen_n = 2'b10;
            mem_we_n    = 1'b0;
            mem_wdata_n = 32'h0;
          end
        end
      end
      WAIT: begin
        cnt_n = cnt + 8'd1;
        // A valid arriving on the last allowed cycle still counts as success.
        if (mem_valid || cnt == TC) begin
          state_n = RESP;
          if (own_d) begin
            d_done_n  = 1'b1;
            d_err_n   = !mem_valid;
            d_rdata_n = mem_valid ? mem_result : 32'h0;
          end else begin
            i_done_n  = 1'b1;
            i_err_n   = !mem_valid;
            i_rdata_n = mem_valid ? mem_result : 32'h0;
          end
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      own_d      <= 1'b0;
      last_d     <= 1'b1;
      mem_enable <= 1'b0;
      mem_addr   <= 32'h0;
      mem_oplen  <= 2'b00;
      mem_we     <= 1'b0;
      mem_wdata  <= 32'h0;
      i_done     <= 1'b0;
      i_err      <= 1'b0;
      i_rdata    <= 32'h0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= 32'h0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      own_d      <= own_d_n;
      last_d     <= last_d_n;
      mem_enable <= mem_enable_n;
      mem_addr   <= mem_addr_n;
      mem_oplen  <= mem_oplen_n;
      mem_we     <= mem_we_n;
      mem_wdata  <= mem_wdata_n;
      i_done     <= i_done_n;
      i_err      <= i_err_n;
      i_rdata    <= i_rdata_n;
      d_done     <= d_done_n;
      d_err      <= d_err_n;
      d_rdata    <= d_rdata_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: round-robin instance checked every cycle against a transaction-timeline
// model, plus a data-priority instance checked through its grant order.
module tb_ram_port_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [1:0]  d_oplen = 2'b00;
  logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
  logic        ram_on = 1'b0, man_v = 1'b0;
  logic [31:0] ram_data = 32'h0;
  logic        auto0 = 1'b0, auto1 = 1'b0;
  wire         mv0 = auto0 | man_v;
  wire         mv1 = auto1 | man_v;

  logic        i_done0, i_err0, d_done0, d_err0, mem_enable0, mem_we0, busy0;
  logic [31:0] i_rdata0, d_rdata0, mem_addr0, mem_wdata0;
  logic [1:0]  mem_oplen0;
  logic        i_done1, i_err1, d_done1, d_err1, mem_enable1, mem_we1, busy1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic [1:0]  mem_oplen1;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_PRIO(1'b0), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done0), .i_rdata(i_rdata0), .i_err(i_err0),
    .d_req(d_req), .d_we(d_we), .d_oplen(d_oplen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done0), .d_rdata(d_rdata0), .d_err(d_err0),
    .mem_enable(mem_enable0), .mem_addr(mem_addr0), .mem_oplen(mem_oplen0), .mem_we(mem_we0),
    .mem_wdata(mem_wdata0), .mem_valid(mv0), .mem_result(ram_data), .busy(busy0));

  ram_port_arbiter #(.DATA_PRIO(1'b1), .TIMEOUT(TO)) u_dp (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done1), .i_rdata(i_rdata1), .i_err(i_err1),
    .d_req(d_req), .d_we(d_we), .d_oplen(d_oplen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done1), .d_rdata(d_rdata1), .d_err(d_err1),
    .mem_enable(mem_enable1), .mem_addr(mem_addr1), .mem_oplen(mem_oplen1), .mem_we(mem_we1),
    .mem_wdata(mem_wdata1), .mem_valid(mv1), .mem_result(ram_data), .busy(busy1));

  // One-cycle RAM: valid follows the enable pulse by one cycle when enabled.
  always @(posedge clk) begin
    auto0 <= ram_on && mem_enable0;
    auto1 <= ram_on && mem_enable1;
  end

  // Timeline model: m_t = cycles since the grant (0 = no transaction), m_fin = response cycle.
  int          m_t = 0;
  bit          m_fin = 1'b0, m_own_d = 1'b0, m_last_d = 1'b1;
  logic        e_en = 0, e_we = 0, e_idone = 0, e_ierr = 0, e_ddone = 0, e_derr = 0, e_busy = 0;
  logic [1:0]  e_oplen = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_irdata = 0, e_drdata = 0;

  always @(posedge clk) begin
    e_en = 0; e_idone = 0; e_ierr = 0; e_irdata = 0; e_ddone = 0; e_derr = 0; e_drdata = 0;
    if (rst) begin
      m_t = 0; m_fin = 0; m_last_d = 1; e_busy = 0;
      e_addr = 0; e_we = 0; e_oplen = 0; e_wdata = 0;
    end else if (m_fin) begin
      m_t = 0; m_fin = 0; e_busy = 0;
    end else if (m_t > 0) begin
      if (mv0 || m_t == TO) begin
        m_fin = 1;
        if (m_own_d) begin
          e_ddone = 1; e_derr = !mv0; e_drdata = mv0 ? ram_data : 32'h0;
        end else begin
          e_idone = 1; e_ierr = !mv0; e_irdata = mv0 ? ram_data : 32'h0;
        end
      end else m_t++;
    end else if (i_req || d_req) begin
      m_own_d  = d_req && (!i_req || m_last_d == 1'b0);
      m_last_d = m_own_d;
      e_en = 1; e_busy = 1; m_t = 1;
      e_addr  = m_own_d ? d_addr  : i_addr;
      e_we    = m_own_d ? d_we    : 1'b0;
      e_oplen = m_own_d ? d_oplen : 2'b10;
      e_wdata = m_own_d ? d_wdata : 32'h0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m_en",     {31'h0, mem_enable0}, {31'h0, e_en});
    check("m_addr",   mem_addr0, e_addr);
    check("m_we",     {31'h0, mem_we0}, {31'h0, e_we});
    check("m_oplen",  {30'h0, mem_oplen0}, {30'h0, e_oplen});
    check("m_wdata",  mem_wdata0, e_wdata);
    check("m_idone",  {31'h0, i_done0}, {31'h0, e_idone});
    check("m_irdata", i_rdata0, e_irdata);
    check("m_ierr",   {31'h0, i_err0}, {31'h0, e_ierr});
    check("m_ddone",  {31'h0, d_done0}, {31'h0, e_ddone});
    check("m_drdata", d_rdata0, e_drdata);
    check("m_derr",   {31'h0, d_err0}, {31'h0, e_derr});
    check("m_busy",   {31'h0, busy0}, {31'h0, e_busy});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input bit want_d, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(want_d ? d_done0 : i_done0) && n < 60);
  endtask

  initial begin
    int n, k0, k1, ni1, extra;
    bit [7:0] seq0, seq1;

    // reset
    rst = 1; tick(2);
    check("rst_busy", {31'h0, busy0}, 32'h0);
    check("rst_en", {31'h0, mem_enable0}, 32'h0);
    check("rst_addr", mem_addr0, 32'h0);
    check("rst_done", {30'h0, i_done0, d_done0}, 32'h0);
    rst = 0; tick(1);

    // single fetch, 1-cycle RAM
    ram_on = 1; ram_data = 32'hDEADBEEF; i_req = 1; i_addr = 32'h8;
    @(negedge clk);
    check("s1_en", {31'h0, mem_enable0}, 32'h1);
    check("s1_addr", mem_addr0, 32'h8);
    check("s1_we", {31'h0, mem_we0}, 32'h0);
    check("s1_oplen", {30'h0, mem_oplen0}, 32'h2);
    @(negedge clk);
    check("s1_en_pulse", {31'h0, mem_enable0}, 32'h0);
    @(negedge clk);
    check("s1_idone", {31'h0, i_done0}, 32'h1);
    check("s1_irdata", i_rdata0, 32'hDEADBEEF);
    check("s1_ierr", {31'h0, i_err0}, 32'h0);
    check("s1_ddone", {31'h0, d_done0}, 32'h0);
    i_req = 0; tick(2);

    // store to the GPIO address
    d_req = 1; d_we = 1; d_oplen = 2'b10; d_addr = 32'hFFFFFFFF; d_wdata = 32'h5A;
    @(negedge clk);
    check("s2_en", {31'h0, mem_enable0}, 32'h1);
    check("s2_we", {31'h0, mem_we0}, 32'h1);
    check("s2_addr", mem_addr0, 32'hFFFFFFFF);
    check("s2_wdata", mem_wdata0, 32'h5A);
    check("s2_busy1", {31'h0, busy0}, 32'h1);
    @(negedge clk);
    check("s2_busy2", {31'h0, busy0}, 32'h1);
    @(negedge clk);
    check("s2_busy3", {31'h0, busy0}, 32'h1);
    check("s2_ddone", {31'h0, d_done0}, 32'h1);
    d_req = 0;
    @(negedge clk);
    check("s2_busy4", {31'h0, busy0}, 32'h0);
    d_we = 0; tick(1);

    // both requesting for four transactions: RR gives I,D,I,D; data priority gives D,D,D,D
    rst = 1; tick(1);
    rst = 0; ram_data = 32'h11112222; i_req = 1; i_addr = 32'h40; d_req = 1; d_addr = 32'h80;
    k0 = 0; k1 = 0; ni1 = 0; seq0 = 0; seq1 = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if ((i_done0 || d_done0) && k0 < 8) begin seq0[k0] = d_done0; k0++; end
      if ((i_done1 || d_done1) && k1 < 8) begin seq1[k1] = d_done1; k1++; end
      if (i_done1) ni1++;
      if (i == 15) begin i_req = 0; d_req = 0; end
    end
    check("s3_rr_cnt", k0, 4);
    check("s3_rr_seq", {28'h0, seq0[3:0]}, 32'hA);
    check("s3_dp_cnt", k1, 4);
    check("s3_dp_seq", {28'h0, seq1[3:0]}, 32'hF);
    check("s3_dp_idone", ni1, 0);
    tick(2);

    // timeout, then recovery
    ram_on = 0; d_req = 1; d_addr = 32'h100;
    wait_done(1, n);
    check("s4_to_lat", n, TO + 1);
    check("s4_derr", {31'h0, d_err0}, 32'h1);
    check("s4_drdata", d_rdata0, 32'h0);
    d_req = 0; tick(2);
    ram_on = 1; ram_data = 32'h12345678; d_req = 1; d_addr = 32'h20;
    wait_done(1, n);
    check("s4_ok_lat", n, 3);
    check("s4_ok_err", {31'h0, d_err0}, 32'h0);
    check("s4_ok_rdata", d_rdata0, 32'h12345678);
    d_req = 0; tick(2);

    // reset during WAIT, stray valid afterwards
    ram_on = 0; d_req = 1; d_addr = 32'h30;
    tick(2);
    rst = 1; d_req = 0;
    @(negedge clk);
    check("s5_rst_out", {mem_addr0[29:0], mem_enable0, busy0}, 32'h0);
    check("s5_rst_done", {i_rdata0[29:0], i_done0, d_done0}, 32'h0);
    rst = 0; man_v = 1;
    @(negedge clk);
    man_v = 0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i_done0 || d_done0 || i_done1 || d_done1 || busy0) extra++;
    end
    check("s5_no_done", extra, 0);
    ram_on = 1; i_req = 1; d_req = 1; i_addr = 32'h44;
    n = 0;
    do begin @(negedge clk); n++; end while (!(i_done0 || d_done0) && n < 20);
    check("s5_first_i", {30'h0, i_done0, d_done0}, 32'h2);
    i_req = 0; d_req = 0; tick(2);

    // valid on the timeout cycle wins
    ram_on = 0; ram_data = 32'hCAFEF00D; d_req = 1; d_addr = 32'h50;
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      if (i == TO) man_v = 1;
    end
    @(negedge clk);
    man_v = 0;
    check("s6_ddone", {31'h0, d_done0}, 32'h1);
    check("s6_derr", {31'h0, d_err0}, 32'h0);
    check("s6_drdata", d_rdata0, 32'hCAFEF00D);
    d_req = 0; tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
